// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit:
// op codes, controller states, accumulate modes, counter sizing.
package muldiv_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

  typedef enum logic [1:0] {
    MK_SET,
    MK_ADD,
    MK_SUB
  } mk_e;

  // Down-counter must hold max(MUL_LAT, WIDTH+1).
  function automatic int cnt_width(int lat, int width);
    int m;
    m = (lat > width + 1) ? lat : width + 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/muldiv_divcore.sv
// Unsigned radix-2 restoring divider, one quotient bit per step.
// Ports: clk_i, dvd_i/dvs_i magnitudes, load_i, step_i, quot_o, rem_o.
module muldiv_divcore #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             load_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;

  // Partial remainder never exceeds divisor, so WIDTH+1 bits
  // suffice; the top bit of diff is the restore decision.
  always_comb begin
    sh   = {r_q, q_q[WIDTH-1]};
    diff = sh - {1'b0, d_q};
  end

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      q_q <= dvd_i;
      d_q <= dvs_i;
      r_q <= '0;
    end else if (step_i) begin
      if (!diff[WIDTH]) begin
        r_q <= diff[WIDTH-1:0];
        q_q <= {q_q[WIDTH-2:0], 1'b1};
      end else begin
        r_q <= sh[WIDTH-1:0];
        q_q <= {q_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quot_o = q_q;
  assign rem_o  = r_q;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: pipelined-latency multiply class,
// iterative divide, MTHI/MTLO. Ports: Clock, Reset, Start, Op,
// RD1, RD2 in; Busy, Done, DivZero, HI, LO out.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = cnt_width(MUL_LAT, WIDTH);

  state_e state_q, state_d;
  mk_e    mk_q, mk_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic done_q, done_d;
  logic dz_q, dz_d;
  logic negq_q, negq_d;
  logic negr_q, negr_d;
  logic divz_q, divz_d;

  logic               sgn;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] hilo;
  logic [WIDTH-1:0]   dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic               div_load;
  logic               div_step;

  // Sign-extending to 2*WIDTH lets one unsigned multiplier
  // produce both signed and unsigned products modulo 2^(2W).
  always_comb begin
    sgn = (Op == OP_MULT) || (Op == OP_MADD) ||
          (Op == OP_MSUB) || (Op == OP_DIV);
    a_ext = sgn ? {{WIDTH{RD1[WIDTH-1]}}, RD1}
                : {{WIDTH{1'b0}}, RD1};
    b_ext = sgn ? {{WIDTH{RD2[WIDTH-1]}}, RD2}
                : {{WIDTH{1'b0}}, RD2};
    prod  = a_ext * b_ext;
    dvd_mag = (sgn && RD1[WIDTH-1]) ? -RD1 : RD1;
    dvs_mag = (sgn && RD2[WIDTH-1]) ? -RD2 : RD2;
    hilo  = {hi_q, lo_q};
  end

  muldiv_divcore #(
    .WIDTH(WIDTH)
  ) u_divcore (
    .clk_i (Clock),
    .dvd_i (dvd_mag),
    .dvs_i (dvs_mag),
    .load_i(div_load),
    .step_i(div_step),
    .quot_o(quot),
    .rem_o (rem)
  );

  always_comb begin
    state_d  = state_q;
    mk_d     = mk_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    prod_d   = prod_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    negq_d   = negq_q;
    negr_d   = negr_q;
    divz_d   = divz_q;
    div_load = 1'b0;
    div_step = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          unique case (Op)
            OP_MULT, OP_MULTU,
            OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU: begin
              prod_d  = prod;
              state_d = S_MUL;
              cnt_d   = CW'(MUL_LAT - 1);
              if (Op == OP_MADD || Op == OP_MADDU)
                mk_d = MK_ADD;
              else if (Op == OP_MSUB || Op == OP_MSUBU)
                mk_d = MK_SUB;
              else
                mk_d = MK_SET;
            end
            OP_DIV, OP_DIVU: begin
              div_load = 1'b1;
              state_d  = S_DIV;
              cnt_d    = CW'(WIDTH - 1);
              negq_d   = sgn && (RD1[WIDTH-1] ^ RD2[WIDTH-1]);
              negr_d   = sgn && RD1[WIDTH-1];
              divz_d   = (RD2 == '0);
            end
            OP_MTHI: hi_d = RD1;
            OP_MTLO: lo_d = RD1;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          unique case (mk_q)
            MK_ADD:  {hi_d, lo_d} = hilo + prod_q;
            MK_SUB:  {hi_d, lo_d} = hilo - prod_q;
            default: {hi_d, lo_d} = prod_q;
          endcase
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIV: begin
        div_step = 1'b1;
        if (cnt_q == '0)
          state_d = S_FIX;
        else
          cnt_d = cnt_q - CW'(1);
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        dz_d    = divz_q;
        // Divide by zero leaves the architectural registers alone.
        if (!divz_q) begin
          lo_d = negq_q ? -quot : quot;
          hi_d = negr_q ? -rem : rem;
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      mk_q    <= MK_SET;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mk_q    <= mk_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      divz_q  <= divz_d;
    end
  end

  assign Busy    = (state_q != S_IDLE);
  assign Done    = done_q;
  assign DivZero = dz_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32, MUL_LAT=5):
// arithmetic reference model plus directed literal checks.
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = 5;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [3:0]    Op    = 4'd0;
  logic [W-1:0]  RD1   = '0;
  logic [W-1:0]  RD2   = '0;
  logic          Busy;
  logic          Done;
  logic          DivZero;
  logic [W-1:0]  HI;
  logic [W-1:0]  LO;

  muldiv_unit #(
    .WIDTH  (W),
    .MUL_LAT(LAT)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .Op     (Op),
    .RD1    (RD1),
    .RD2    (RD2),
    .Busy   (Busy),
    .Done   (Done),
    .DivZero(DivZero),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h",
               nm, cyc, got, want);
    end
  endtask

  // Reference model: completion result from plain arithmetic.
  function automatic logic [63:0] finish(
    input logic [3:0] op, input logic [31:0] a,
    input logic [31:0] b, input logic [63:0] hl);
    longint sa, sb, q, r;
    logic [63:0] ps, pu, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = sa * sb;
    pu = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0: return ps;
      4'd1: return pu;
      4'd6: return hl + ps;
      4'd7: return hl + pu;
      4'd8: return hl - ps;
      4'd9: return hl - pu;
      4'd2: begin
        if (b == 0) return hl;
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
      end
      4'd3: begin
        if (b == 0) return hl;
        return {a % b, a / b};
      end
      default: return hl;
    endcase
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] p_a = '0, p_b = '0;
  logic [3:0]  p_op = '0;
  int          m_rem = 0;
  logic        m_done = 1'b0, m_dz = 1'b0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_rem  <= 0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          {m_hi, m_lo} <= finish(p_op, p_a, p_b, {m_hi, m_lo});
          m_done <= 1'b1;
          m_dz   <= (p_op == 4'd2 || p_op == 4'd3) && p_b == 0;
        end
      end else if (Start) begin
        p_op <= Op;
        p_a  <= RD1;
        p_b  <= RD2;
        if (Op <= 4'd1 || (Op >= 4'd6 && Op <= 4'd9))
          m_rem <= LAT;
        else if (Op == 4'd2 || Op == 4'd3)
          m_rem <= W + 1;
        else if (Op == 4'd4)
          m_hi <= RD1;
        else if (Op == 4'd5)
          m_lo <= RD1;
      end
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("busy", 64'(Busy), 64'(m_rem != 0));
      chk("done", 64'(Done), 64'(m_done));
      chk("divzero", 64'(DivZero), 64'(m_dz));
      chk("hi", 64'(HI), 64'(m_hi));
      chk("lo", 64'(LO), 64'(m_lo));
    end
  end

  // Caller sits at a negedge; returns at the negedge showing Done.
  task automatic wait_done(output int nb);
    bit seen;
    seen = 1'b0;
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      Start = 1'b0;
      RD1 = $urandom;
      RD2 = $urandom;
      Op  = 4'($urandom);
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (Busy) nb++;
    end
    chk("done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, output int nb);
    Start = 1'b1;
    Op    = op;
    RD1   = a;
    RD2   = b;
    wait_done(nb);
  endtask

  task automatic mov(input logic [3:0] op, input logic [31:0] a);
    Start = 1'b1;
    Op    = op;
    RD1   = a;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  int nb;

  initial begin
    Start = 1'b1;
    Op    = 4'd4;
    RD1   = 32'd55;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    Start = 1'b0;
    chk_en = 1'b1;
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);

    run(4'd0, 32'hFFFFFFF9, 32'd13, nb);
    chk("mult_busy_len", 64'(nb), 64'd5);
    chk("mult_hi", 64'(HI), 64'hFFFFFFFF);
    chk("mult_lo", 64'(LO), 64'hFFFFFFA5);

    run(4'd1, 32'hFFFFFFF9, 32'd13, nb);
    chk("multu_hi", 64'(HI), 64'h0000000C);
    chk("multu_lo", 64'(LO), 64'hFFFFFFA5);

    run(4'd0, 32'hFFFFFFF9, 32'd13, nb);
    run(4'd6, 32'd10, 32'd10, nb);
    chk("madd_hi", 64'(HI), 64'd0);
    chk("madd_lo", 64'(LO), 64'd9);

    run(4'd8, 32'd3, 32'd3, nb);
    chk("msub_lo", 64'(LO), 64'd0);
    run(4'd9, 32'd1, 32'd1, nb);
    chk("msubu_hi", 64'(HI), 64'hFFFFFFFF);
    chk("msubu_lo", 64'(LO), 64'hFFFFFFFF);
    run(4'd7, 32'd1, 32'd1, nb);
    chk("maddu_wrap", {32'(HI), 32'(LO)}, 64'd0);
    run(4'd0, 32'hFFFFFFFB, 32'hFFFFFFFA, nb);
    chk("mult_negneg", 64'(LO), 64'd30);
    run(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, nb);
    run(4'd6, 32'h80000000, 32'h80000000, nb);

    run(4'd2, 32'hFFFFFFF8, 32'd3, nb);
    chk("div_busy_len", 64'(nb), 64'd33);
    chk("div_lo", 64'(LO), 64'hFFFFFFFE);
    chk("div_hi", 64'(HI), 64'hFFFFFFFE);

    run(4'd2, 32'h80000000, 32'hFFFFFFFF, nb);
    chk("div_ovf_lo", 64'(LO), 64'h80000000);
    chk("div_ovf_hi", 64'(HI), 64'd0);

    run(4'd2, 32'd7, 32'hFFFFFFFE, nb);
    chk("div_7_m2", {32'(HI), 32'(LO)}, 64'h00000001_FFFFFFFD);
    run(4'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, nb);
    run(4'd3, 32'd100, 32'd7, nb);
    chk("divu_100_7", {32'(HI), 32'(LO)}, 64'h00000002_0000000E);
    run(4'd3, 32'hFFFFFFFF, 32'd2, nb);

    mov(4'd4, 32'd100);
    mov(4'd5, 32'd300);
    run(4'd3, 32'd8, 32'd0, nb);
    chk("dz_busy_len", 64'(nb), 64'd33);
    chk("dz_flag", 64'(DivZero), 64'd1);
    chk("dz_hi", 64'(HI), 64'd100);
    chk("dz_lo", 64'(LO), 64'd300);
    run(4'd2, 32'd8, 32'd0, nb);

    Start = 1'b1;
    Op    = 4'd2;
    RD1   = 32'd53;
    RD2   = 32'd5;
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    Start = 1'b1;
    Op    = 4'd4;
    RD1   = 32'd5;
    wait_done(nb);
    chk("ign_hi", 64'(HI), 64'd3);
    chk("ign_lo", 64'(LO), 64'd10);
    mov(4'd5, 32'd77);
    chk("b2b_mtlo", 64'(LO), 64'd77);

    mov(4'd12, 32'd999);
    chk("noop_busy", 64'(Busy), 64'd0);

    Start = 1'b1;
    Op    = 4'd2;
    RD1   = 32'd100;
    RD2   = 32'd7;
    @(negedge Clock);
    Start = 1'b0;
    repeat (9) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_hi", 64'(HI), 64'd0);
    chk("abort_lo", 64'(LO), 64'd0);
    chk("abort_done", 64'(Done), 64'd0);
    Reset = 1'b0;
    repeat (40) @(negedge Clock);

    run(4'd0, 32'd2, 32'd3, nb);
    chk("recover_lo", 64'(LO), 64'd6);

    @(negedge Clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 The block SHALL have parameter MUL_LAT, default 5, giving the multiply-class latency in cycles (legal range 1..16).
REQ-003 The block SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port Start, input, 1, a request to issue Op with the current operands.
REQ-006 The block SHALL have port Op, input, 4, the operation code.
REQ-007 The block SHALL have ports RD1 and RD2, input, WIDTH each, the operands: RD1 is the multiplicand or dividend, RD2 the multiplier or divisor.
REQ-008 The block SHALL have port Busy, output, 1, high while a multi-cycle operation is in flight.
REQ-009 The block SHALL have port Done, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port DivZero, output, 1, asserted together with Done when a divide had RD2 equal to 0.
REQ-011 The block SHALL have ports HI and LO, output, WIDTH each, the architectural result registers.

Function
REQ-012 Op encoding SHALL be: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; codes 10..15 are no-ops.
REQ-013 Start SHALL be accepted only when Busy is 0; Start while Busy is 1 SHALL be ignored, with no effect on state or outputs.
REQ-014 Operands and Op SHALL be captured at the accepting edge; later changes to RD1, RD2 or Op SHALL have no effect on the operation in flight.
REQ-015 MTHI and MTLO SHALL write RD1 to HI or LO at the accepting edge, SHALL NOT raise Busy and SHALL NOT pulse Done.
REQ-016 Multiply class (MULT, MULTU, MADD, MADDU, MSUB, MSUBU): Busy SHALL be high for exactly MUL_LAT cycles after the accepting edge.
REQ-017 For the multiply class, {HI,LO} SHALL update at the edge where Busy falls.
REQ-018 MULT and MULTU SHALL set {HI,LO} to the 2*WIDTH-bit product, signed and unsigned respectively.
REQ-019 MADD/MADDU SHALL set {HI,LO} to {HI,LO} plus the product, and MSUB/MSUBU to {HI,LO} minus the product, computed modulo 2^(2*WIDTH) using the {HI,LO} value held at completion.
REQ-020 Divide class (DIV, DIVU) SHALL be an iterative radix-2 restoring divide taking one quotient bit per cycle plus one sign-fixup cycle, so Busy is high for exactly WIDTH+1 cycles.
REQ-021 At divide completion, LO SHALL hold the quotient and HI the remainder.
REQ-022 DIV SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-023 DIV with the most-negative dividend and a divisor of -1 SHALL give LO equal to the most-negative value and HI equal to 0.
REQ-024 A divide with RD2 equal to 0 SHALL run the full WIDTH+1 cycles, leave HI and LO unchanged, and assert DivZero together with Done.
REQ-025 Done SHALL be high for the single cycle following the completing edge, in which HI and LO already show the new values.
REQ-026 A new Start SHALL be accepted in the same cycle that Done is high (back-to-back issue).
REQ-027 The internal controller SHALL be an FSM with states IDLE, MUL, DIV and FIX and a down-counter for the remaining cycles.
REQ-028 FSM transitions SHALL be: IDLE->MUL or IDLE->DIV on accept; MUL->IDLE when the counter reaches 0; DIV->FIX after WIDTH iterations; FIX->IDLE.

Reset
REQ-029 Reset SHALL force HI=0, LO=0, Busy=0, Done=0, DivZero=0 and the FSM state to IDLE at the next edge.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no partial result written.
REQ-031 Reset SHALL take priority over a Start presented in the same cycle.

Structure
REQ-032 Package muldiv_pkg SHALL hold the Op codes, the FSM state encoding and the counter width derived from max(MUL_LAT, WIDTH+1).
REQ-033 The iterative divider datapath SHALL be the single sub-module muldiv_divcore (parameter WIDTH; ports: operands, load, step, quotient, remainder).
REQ-034 Multiply SHALL be computed combinationally at accept, registered, and held until the latency counter expires.

Verification (WIDTH=32, MUL_LAT=5)
REQ-035 MULT RD1=-7, RD2=13 -> Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFA5 and Done pulses once.
REQ-036 MULTU RD1=0xFFFFFFF9, RD2=13 -> HI=0x0000000C, LO=0xFFFFFFA5; MADD 10*10 issued after a MULT -7*13 -> HI=0, LO=9.
REQ-037 DIV -8/3 -> Busy high for 33 cycles, then LO=0xFFFFFFFE, HI=0xFFFFFFFE; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-038 DIVU 8/0 issued with HI=100, LO=300 -> after 33 cycles, Done and DivZero high together and HI=100, LO=300 unchanged.
REQ-039 A Start of MTHI RD1=5 while a DIV is Busy -> ignored and HI unchanged at completion; an MTLO issued in the Done cycle -> accepted.
REQ-040 Reset asserted 10 cycles into a DIV -> the next cycle has Busy=0, HI=0, LO=0 and no Done pulse.
